o_acc_buf: RTL and testbench

- Multi-channel output accumulation buffer for the systolic array.
- Each column (channel) of the array owns one DEPTH-entry accumulator bank. Partial sums for all channels arrive together, one row per beat, and are either overwritten or accumulated with signed saturation.
- Banks can be bias-preloaded per row. A finished tile is streamed out over a valid/ready port.
- Sits between the PE array's south edge and the write-back DMA.

---
 rtl/o_acc_pkg.sv | 41 ++++
 rtl/o_acc_bank.sv | 65 ++++++
 rtl/o_acc_buf.sv | 160 ++++++++++++++++
 tb/tb_o_acc_buf.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/o_acc_pkg.sv
// Shared types and helpers for the output accumulation buffer.
package o_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Widest accumulator supported by sat_add; callers sign-extend into it.
    localparam int MAX_W = 64;

    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Returns {clamped, sum}; the sum sits in the low w bits, sign-correct.
    function automatic logic [MAX_W:0] sat_add(input logic signed [MAX_W-1:0] a,
                                               input logic signed [MAX_W-1:0] b,
                                               input int                      w);
        logic signed [MAX_W:0] sum;
        logic signed [MAX_W:0] hi;
        logic signed [MAX_W:0] lo;
        logic        [MAX_W:0] res;
        sum = {a[MAX_W-1], a} + {b[MAX_W-1], b};
        hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo  = -(65'sd1 <<< (w - 1));
        res = '0;
        if (sum > hi) begin
            res[MAX_W-1:0] = hi[MAX_W-1:0];
            res[MAX_W]     = 1'b1;
        end else if (sum < lo) begin
            res[MAX_W-1:0] = lo[MAX_W-1:0];
            res[MAX_W]     = 1'b1;
        end else begin
            res[MAX_W-1:0] = sum[MAX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/o_acc_bank.sv
// One channel's DEPTH x WIDTH accumulator bank: overwrite/accumulate/bias/clear writes.
// Read data registered (1 cycle); no flow control, the parent sequences all accesses.
module o_acc_bank
    import o_acc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             acc_we_i,
    input  logic             first_i,
    input  logic [AW-1:0]    acc_addr_i,
    input  logic [WIDTH-1:0] acc_data_i,
    input  logic             bias_we_i,
    input  logic [AW-1:0]    bias_addr_i,
    input  logic [WIDTH-1:0] bias_data_i,
    input  logic             clr_i,
    input  logic [AW-1:0]    clr_addr_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             sat_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] rd_d;
    logic [MAX_W:0]   add_res;

    always_comb begin
        mem_d   = mem_q;
        add_res = sat_add(MAX_W'($signed(mem_q[acc_addr_i])),
                          MAX_W'($signed(acc_data_i)), WIDTH);
        if (acc_we_i) begin
            mem_d[acc_addr_i] = first_i ? acc_data_i : add_res[WIDTH-1:0];
        end
        if (bias_we_i) begin
            mem_d[bias_addr_i] = bias_data_i;
        end
        // Clear targets the row being handed off; it never aliases the row read this cycle.
        if (clr_i) begin
            mem_d[clr_addr_i] = '0;
        end
        rd_d = rd_en_i ? mem_q[rd_addr_i] : rd_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
        end
    end

    assign rd_data_o = rd_q;
    assign sat_o     = acc_we_i & ~first_i & add_res[MAX_W];

endmodule

// File: rtl/o_acc_buf.sv
// Multi-channel accumulation buffer: one psum row per beat in, one drained row per beat out.
// First drained row 2 cycles after drain_start_i; out_data_o held while out_ready_i is low.
module o_acc_buf
    import o_acc_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 8,
    parameter int CH           = 4,
    parameter int CLR_ON_DRAIN = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [CH*WIDTH-1:0]        psum_i,
    input  logic                       psum_vi,
    input  logic                       first_vi,
    input  logic                       bias_we_i,
    input  logic [$clog2(DEPTH)-1:0]   bias_addr_i,
    input  logic [CH*WIDTH-1:0]        bias_data_i,
    input  logic                       drain_start_i,
    output logic [CH*WIDTH-1:0]        out_data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       out_last_o,
    output logic                       busy_o,
    output logic                       sat_o,
    output logic                       err_o
);

    localparam int AW = addr_w(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic          vld_q, vld_d;
    logic          sat_q, sat_d;
    logic          err_q, err_d;

    logic          acc_we, bias_we, clr, rd_en, drain_ok, hs, last, bias_ok;
    logic [AW-1:0] rd_addr;
    logic [CH-1:0] bank_sat;

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        vld_d    = vld_q;
        err_d    = err_q;
        acc_we   = 1'b0;
        bias_we  = 1'b0;
        clr      = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = rptr_q;
        drain_ok = 1'b0;
        hs       = vld_q & out_ready_i;
        last     = (rptr_q == AW'(DEPTH - 1));
        bias_ok  = ({1'b0, bias_addr_i} < (AW + 1)'(DEPTH));

        case (state_q)
            IDLE, ACC: begin
                if (psum_vi) begin
                    acc_we  = 1'b1;
                    state_d = ACC;
                    wptr_d  = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
                    if (bias_we_i || drain_start_i) begin
                        err_d = 1'b1;
                    end
                end else begin
                    if (drain_start_i) begin
                        drain_ok = 1'b1;
                        state_d  = DRAIN;
                        rptr_d   = '0;
                        err_d    = 1'b0;
                    end
                    // Flags are cleared by the drain first so a bad bias address still sticks.
                    if (bias_we_i) begin
                        if (bias_ok) begin
                            bias_we = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (psum_vi || bias_we_i) begin
                    err_d = 1'b1;
                end
                if (!vld_q) begin
                    rd_en   = 1'b1;
                    rd_addr = rptr_q;
                    vld_d   = 1'b1;
                end else if (hs) begin
                    clr = (CLR_ON_DRAIN != 0);
                    if (last) begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                        rptr_d  = '0;
                        wptr_d  = '0;
                    end else begin
                        rptr_d  = rptr_q + 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = rptr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sat_d = drain_ok ? 1'b0 : (sat_q | (|bank_sat));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            vld_q   <= 1'b0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            vld_q   <= vld_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_bank
        o_acc_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_bank (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .acc_we_i    (acc_we),
            .first_i     (first_vi),
            .acc_addr_i  (wptr_q),
            .acc_data_i  (psum_i[c*WIDTH +: WIDTH]),
            .bias_we_i   (bias_we),
            .bias_addr_i (bias_addr_i),
            .bias_data_i (bias_data_i[c*WIDTH +: WIDTH]),
            .clr_i       (clr),
            .clr_addr_i  (rptr_q),
            .rd_en_i     (rd_en),
            .rd_addr_i   (rd_addr),
            .rd_data_o   (out_data_o[c*WIDTH +: WIDTH]),
            .sat_o       (bank_sat[c])
        );
    end

    assign out_valid_o = vld_q;
    assign out_last_o  = vld_q & last;
    assign busy_o      = (state_q == DRAIN);
    assign sat_o       = sat_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_o_acc_buf.sv
// Directed bench for o_acc_buf: accumulate, overwrite, saturation, backpressure, collisions, reset.
module tb_o_acc_buf;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int C  = 4;
    localparam int D2 = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [C*W-1:0]   psum = '0;
    logic             psum_v = 1'b0;
    logic             first_v = 1'b0;
    logic             bias_we = 1'b0;
    logic [2:0]       bias_addr = '0;
    logic [C*W-1:0]   bias_data = '0;
    logic             drain_start = 1'b0;
    logic [C*W-1:0]   out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic             busy;
    logic             sat;
    logic             err;

    // Second instance: non-power-of-two depth, so an out-of-range bias address is expressible.
    logic             p2_v = 1'b0;
    logic             b2_we = 1'b0;
    logic [2:0]       b2_addr = '0;
    logic [C*W-1:0]   b2_data = '0;
    logic             d2_start = 1'b0;
    logic             r2_ready = 1'b0;
    logic [C*W-1:0]   o2_data;
    logic             o2_valid, o2_last, o2_busy, o2_sat, o2_err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [C*W-1:0] got_row [D];
    logic [W-1:0]   exp_v   [D][C];

    always #5 clk = ~clk;

    o_acc_buf #(.WIDTH(W), .DEPTH(D), .CH(C), .CLR_ON_DRAIN(1)) dut (
        .clk_i(clk), .rst_i(rst), .psum_i(psum), .psum_vi(psum_v), .first_vi(first_v),
        .bias_we_i(bias_we), .bias_addr_i(bias_addr), .bias_data_i(bias_data),
        .drain_start_i(drain_start), .out_data_o(out_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_last_o(out_last), .busy_o(busy), .sat_o(sat), .err_o(err)
    );

    o_acc_buf #(.WIDTH(W), .DEPTH(D2), .CH(C), .CLR_ON_DRAIN(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .psum_i(psum), .psum_vi(p2_v), .first_vi(first_v),
        .bias_we_i(b2_we), .bias_addr_i(b2_addr), .bias_data_i(b2_data),
        .drain_start_i(d2_start), .out_data_o(o2_data), .out_valid_o(o2_valid),
        .out_ready_i(r2_ready), .out_last_o(o2_last), .busy_o(o2_busy), .sat_o(o2_sat), .err_o(o2_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [C*W-1:0] splat(input logic [W-1:0] v);
        return {C{v}};
    endfunction

    task automatic bias_row(input int r, input logic [C*W-1:0] d);
        bias_we   = 1'b1;
        bias_addr = 3'(r);
        bias_data = d;
        @(negedge clk);
        bias_we   = 1'b0;
    endtask

    task automatic psum_row(input logic [C*W-1:0] d, input logic first);
        psum_v  = 1'b1;
        first_v = first;
        psum    = d;
        @(negedge clk);
        psum_v  = 1'b0;
        first_v = 1'b0;
    endtask

    task automatic exp_fill(input logic [W-1:0] v);
        for (int r = 0; r < D; r++)
            for (int c = 0; c < C; c++)
                exp_v[r][c] = v;
    endtask

    task automatic compare_rows(input string tag);
        for (int r = 0; r < D; r++)
            for (int c = 0; c < C; c++)
                check($sformatf("%s_r%0d_c%0d", tag, r, c), got_row[r][c*W +: W], exp_v[r][c]);
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 per valid cycle.
    // inject: psum, bias and drain_start pulsed in the first drain cycle.
    task automatic drain(input string tag, input int mode, input bit inject);
        int beats = 0;
        int cyc = 0;
        int k = 0;
        logic stalled = 1'b0;
        logic [C*W-1:0] held = '0;
        logic [3:0] pat = 4'b1001;
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        out_ready   = 1'b0;
        check({tag, "_busy_on"}, busy, 1);
        check({tag, "_vld_gap"}, out_valid, 0);
        while (beats < D && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (inject) begin
                psum_v      = (cyc == 1);
                first_v     = (cyc == 1);
                psum        = splat(32'h55);
                bias_we     = (cyc == 1);
                bias_addr   = 3'd0;
                bias_data   = splat(32'h66);
                drain_start = (cyc == 1);
            end
            if (out_valid) begin
                out_ready = (mode == 0) ? 1'b1 : pat[k % 4];
                k++;
                if (stalled) check({tag, "_stall_hold"}, out_data, held);
                if (out_ready) begin
                    got_row[beats] = out_data;
                    check({tag, "_last"}, out_last, (beats == D - 1));
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end
        end
        if (beats < D) check({tag, "_timeout_beats"}, beats, D);
        if (mode == 0) check({tag, "_consecutive"}, cyc, D);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_vld_off"}, out_valid, 0);
        check({tag, "_busy_off"}, busy, 0);
    endtask

    initial begin
        int cnt;
        int cyc;
        logic [C*W-1:0] d;

        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_last", out_last, 0);
        check("rst_sat", sat, 0);
        check("rst_err", err, 0);
        check("rst_data", out_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // Accumulate: bias 10*r plus two passes of +1.
        for (int r = 0; r < D; r++) bias_row(r, splat(32'(10 * r)));
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < D; r++) psum_row(splat(32'd1), 1'b0);
        check("acc_sat", sat, 0);
        check("acc_err", err, 0);
        drain("acc", 0, 1'b0);
        for (int r = 0; r < D; r++)
            for (int c = 0; c < C; c++) exp_v[r][c] = 32'(10 * r + 2);
        compare_rows("acc");

        // Overwrite then accumulate; then the cleared banks drain as zero.
        for (int r = 0; r < D; r++) psum_row(splat(32'd5), 1'b1);
        for (int r = 0; r < D; r++) psum_row(splat(32'd3), 1'b0);
        drain("ovw", 0, 1'b0);
        exp_fill(32'd8);
        compare_rows("ovw");
        drain("clr", 0, 1'b0);
        exp_fill(32'd0);
        compare_rows("clr");

        // Saturation at both rails.
        bias_row(0, {96'd0, 32'h7FFF_FFF0});
        bias_row(1, {64'd0, 32'h8000_0005, 32'd0});
        psum_row({96'd0, 32'h20}, 1'b0);
        psum_row({64'd0, 32'hFFFF_FFF0, 32'd0}, 1'b0);
        for (int r = 2; r < D; r++) psum_row('0, 1'b0);
        check("sat_set", sat, 1);
        check("sat_noerr", err, 0);
        drain("sat", 0, 1'b0);
        exp_fill(32'd0);
        exp_v[0][0] = 32'h7FFF_FFFF;
        exp_v[1][1] = 32'h8000_0000;
        compare_rows("sat");
        check("sat_cleared", sat, 0);

        // Backpressure with distinct per-row/channel values.
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < C; c++) begin
                d[c*W +: W] = 32'(100 * r + c);
                exp_v[r][c] = 32'(100 * r + c);
            end
            bias_row(r, d);
        end
        drain("bp", 1, 1'b0);
        compare_rows("bp");

        // psum and bias in the same cycle: psum wins.
        psum_v = 1'b1; first_v = 1'b1; psum = splat(32'd7);
        bias_we = 1'b1; bias_addr = 3'd3; bias_data = splat(32'd99);
        @(negedge clk);
        psum_v = 1'b0; first_v = 1'b0; bias_we = 1'b0;
        check("coll_err", err, 1);
        drain("coll", 0, 1'b0);
        exp_fill(32'd0);
        for (int c = 0; c < C; c++) exp_v[0][c] = 32'd7;
        compare_rows("coll");
        check("coll_err_clr", err, 0);

        // Writes during DRAIN are dropped.
        for (int r = 0; r < D; r++) begin
            bias_row(r, splat(32'(r + 1)));
            for (int c = 0; c < C; c++) exp_v[r][c] = 32'(r + 1);
        end
        drain("ddrop", 0, 1'b1);
        compare_rows("ddrop");
        check("ddrop_err", err, 1);

        // Reset in the middle of a drain.
        for (int r = 0; r < D; r++) bias_row(r, splat(32'(17 * (r + 1))));
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (out_valid) cnt++;
        end
        check("mrst_beats", cnt, 3);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_data", out_data, 0);
        check("mrst_err", err, 0);
        @(negedge clk);
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        drain("post_rst", 0, 1'b0);
        exp_fill(32'd0);
        compare_rows("post_rst");

        // DEPTH=6: address 6 is out of range, address 5 is the top valid row.
        check("d6_err_idle", o2_err, 0);
        b2_we = 1'b1; b2_addr = 3'd6; b2_data = splat(32'h1234);
        @(negedge clk);
        b2_we = 1'b0;
        check("d6_err_oob", o2_err, 1);
        b2_we = 1'b1; b2_addr = 3'd5; b2_data = splat(32'hAB);
        @(negedge clk);
        b2_we = 1'b0;
        d2_start = 1'b1;
        @(negedge clk);
        d2_start = 1'b0;
        r2_ready = 1'b1;
        check("d6_err_clr", o2_err, 0);
        cnt = 0;
        cyc = 0;
        while (cnt < D2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (o2_valid) begin
                check($sformatf("d6_row%0d", cnt), o2_data, (cnt == 5) ? splat(32'hAB) : '0);
                check($sformatf("d6_last%0d", cnt), o2_last, (cnt == D2 - 1));
                cnt++;
            end
        end
        check("d6_beats", cnt, D2);
        @(negedge clk);
        r2_ready = 1'b0;
        check("d6_vld_off", o2_valid, 0);
        check("d6_busy_off", o2_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
